llc_rst_flush_seq: RTL and testbench
====================================

# llc_rst_flush_seq

Set-sweep sequencer for the LLC reset and flush operations. It walks every LLC set in order. For each set it raises `is_rst_to_resume` or `is_flush_to_resume` toward the LLC pipeline, which drives the write-back/update stage, and advances only when the update stage returns `incr_rst_flush_stalled_set` for that set. It also arbitrates reset against flush requests and reports completion to the LLC core control.

## Interface
- `NUM_SETS`, default `` `LLC_SETS ``: number of sets swept. Power of two, ≥2.
- `SET_W`, default `$clog2(NUM_SETS)`: width of the set index.
- `WDOG_CYCLES`, default 1024: watchdog limit in cycles. Used only when `LLC_RST_FLUSH_WDOG_EN` is defined.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous reset, active-low.
- `rst_start` in 1: one-cycle pulse requesting a full reset sweep.
- `flush_start` in 1: one-cycle pulse requesting a flush sweep.
- `grant_ready` in 1: the pipeline accepts a sweep step this cycle.
- `incr_rst_flush_stalled_set` in 1: the update stage has finished the current set.
- `is_rst_to_resume` out 1: reset step request for set `rst_flush_set`.
- `is_flush_to_resume` out 1: flush step request for set `rst_flush_set`.
- `rst_flush_set` out `SET_W`: index of the set being swept.
- `rst_flush_busy` out 1: a sweep is active.
- `rst_done` out 1: one-cycle pulse when a reset sweep completes.
- `flush_done` out 1: one-cycle pulse when a flush sweep completes.
- `rst_flush_err` out 1: sticky watchdog error. Tied to 0 when the macro is not defined.

## Operation
- States: `IDLE`, `RST_ISSUE`, `RST_WAIT`, `FL_ISSUE`, `FL_WAIT`.
- Reset (`rst`=0) forces the following: state=`RST_ISSUE`, set=0, `flush_pend`=0, error=0. The first cycle after `rst` deasserts therefore starts a power-up reset sweep with no `rst_start` needed.
- Reset values of the outputs: `is_rst_to_resume`=1, `is_flush_to_resume`=0, `rst_flush_set`=0, `rst_flush_busy`=1, `rst_done`=0, `flush_done`=0, `rst_flush_err`=0.
- `IDLE`:
  - `rst_start` → `RST_ISSUE` with set=0.
  - Otherwise, `flush_start` or `flush_pend` → `FL_ISSUE` with set=0, and `flush_pend` clears.
- `*_ISSUE`:
  - Asserts the matching `is_*_to_resume` output.
  - If `grant_ready`=1, the next state is `*_WAIT`. If `grant_ready`=0, the state holds.
- `*_WAIT`:
  - No request is asserted. The state waits for `incr_rst_flush_stalled_set`.
  - On the increment with set<`NUM_SETS`-1: set+1 and return to `*_ISSUE`.
  - On the increment with set=`NUM_SETS`-1: pulse `rst_done` or `flush_done` next cycle, set wraps to 0, go to `IDLE`.
- `incr_rst_flush_stalled_set` is ignored in `IDLE` and `*_ISSUE`.
- `flush_start` during a reset sweep, or during a flush sweep, sets `flush_pend`. The pending flush starts on the first `IDLE` cycle after the current sweep ends. Multiple pulses collapse into one pending flush.
- `rst_start` during a flush sweep preempts it:
  - Next state is `RST_ISSUE` with set=0.
  - No `flush_done` is pulsed.
  - `flush_pend` clears.
- `rst_start` during a reset sweep restarts that sweep at set 0.
- Simultaneous `rst_start` and `flush_start` in `IDLE`: the reset sweep starts and `flush_pend` is set.
- `rst_flush_busy` = (state≠`IDLE`).

## Timing
- The request outputs are a combinational decode of the registered state. `rst_flush_set`, the done pulses, `rst_flush_err` and state are all registered.
- A step handshake completes in the cycle where `*_ISSUE` and `grant_ready`=1 are both true.
- Minimum 2 cycles per set: the grant cycle, then a `WAIT` cycle that sees the increment.
- A full sweep takes at least 2·`NUM_SETS` cycles. The done pulse occurs in the cycle after the last increment.
- `flush_start` in the same cycle as `rst_done` starts the flush on the following cycle.

## Configuration
- `LLC_RST_FLUSH_WDOG_EN` defined:
  - A counter of `$clog2(WDOG_CYCLES)+1` bits counts consecutive cycles spent in `*_WAIT`. It clears on leaving `WAIT`.
  - When the counter reaches `WDOG_CYCLES`, `rst_flush_err` sets and stays 1 until `rst`. The sweep continues waiting.
- `LLC_RST_FLUSH_WDOG_EN` not defined: no counter is built and `rst_flush_err`=0 constantly.

## Structure
- The state enum `llc_rst_flush_state_t` and the `WDOG_CYCLES` default go in the shared cache types/consts package, next to the other LLC typedefs.
- `rst_flush_set` uses the package set-index type when `SET_W` equals `` `LLC_SET_BITS ``.
- One sub-module: `llc_rst_flush_wdog`, holding the counter and sticky error. It is instantiated only under the macro.

## Test plan
- Power-up sweep:
  - Stimulus: `NUM_SETS`=4, `grant_ready`=1, increment one cycle after each grant.
  - Required: sets 0,1,2,3 in order; `rst_done` pulses 8 cycles after `rst` deasserts; then `IDLE`, busy=0.
- Grant stall: `grant_ready`=0 for 5 cycles while in set 2 `ISSUE` → request is held, set stays 2, no advance, `rst_done` is delayed by 5 cycles.
- Pending flush:
  - Stimulus: `flush_start` at set 1 of the reset sweep.
  - Required: `rst_done`, then `FL_ISSUE` with set=0 the next cycle; `flush_done` after 8 more cycles.
- Reset preempts flush: `rst_start` at flush set 2 → `is_rst_to_resume`=1 with set=0 the next cycle, and `flush_done` never pulses.
- Mid-operation reset: `rst`=0 during `FL_WAIT` at set 3 → next cycle shows state `RST_ISSUE`, set=0, `flush_pend`=0.
- Watchdog:
  - Stimulus: macro defined, `WDOG_CYCLES`=16, increment withheld.
  - Required: `rst_flush_err`=1 after 16 `WAIT` cycles and it stays 1 after the increment arrives. Without the macro, the error stays 0.

Source files
------------

// File: rtl/llc_rst_flush_pkg.sv
// Shared LLC types and constants used by the reset/flush set sweeper.
// Supplies LLC_SETS / LLC_SET_BITS fallbacks when the build does not define them.
`ifndef LLC_SETS
`define LLC_SETS 1024
`endif
`ifndef LLC_SET_BITS
`define LLC_SET_BITS 10
`endif

package llc_rst_flush_pkg;

  localparam int unsigned LLC_SETS_DEF    = `LLC_SETS;
  localparam int unsigned LLC_SET_BITS    = `LLC_SET_BITS;
  localparam int unsigned WDOG_CYCLES_DEF = 1024;

  typedef logic [LLC_SET_BITS-1:0] llc_set_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RST_ISSUE = 3'd1,
    RST_WAIT  = 3'd2,
    FL_ISSUE  = 3'd3,
    FL_WAIT   = 3'd4
  } llc_rst_flush_state_t;

endpackage

// File: rtl/llc_rst_flush_wdog.sv
// Watchdog for the reset/flush sweeper: counts consecutive WAIT cycles and
// raises a sticky error once the limit is reached.
module llc_rst_flush_wdog #(
  parameter int unsigned WDOG_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic in_wait,
  output logic err
);

  localparam int unsigned CNT_W = $clog2(WDOG_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WDOG_CYCLES);

  logic [CNT_W-1:0] cnt;

  // Counter saturates at the limit; the error flag latches on the cycle the limit is hit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (!in_wait) begin
        cnt <= '0;
      end else if (cnt != LIMIT) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (in_wait && (cnt == LIMIT - CNT_W'(1))) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/llc_rst_flush_seq.sv
// LLC reset/flush set sweeper: walks every set, handshakes each step with the
// pipeline and arbitrates reset against flush. Watchdog under LLC_RST_FLUSH_WDOG_EN.
module llc_rst_flush_seq
  import llc_rst_flush_pkg::*;
#(
  parameter int unsigned NUM_SETS    = LLC_SETS_DEF,
  parameter int unsigned SET_W       = $clog2(NUM_SETS),
  parameter int unsigned WDOG_CYCLES = WDOG_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rst_start,
  input  logic             flush_start,
  input  logic             grant_ready,
  input  logic             incr_rst_flush_stalled_set,
  output logic             is_rst_to_resume,
  output logic             is_flush_to_resume,
  output logic [SET_W-1:0] rst_flush_set,
  output logic             rst_flush_busy,
  output logic             rst_done,
  output logic             flush_done,
  output logic             rst_flush_err
);

  localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);

  if ((NUM_SETS < 2) || ((NUM_SETS & (NUM_SETS - 1)) != 0)) begin : g_bad_sets
    $error("llc_rst_flush_seq: NUM_SETS must be a power of two >= 2");
  end
  if (WDOG_CYCLES < 1) begin : g_bad_wdog
    $error("llc_rst_flush_seq: WDOG_CYCLES must be >= 1");
  end

  llc_rst_flush_state_t state_q, state_n;
  logic [SET_W-1:0]     set_q, set_n;
  logic                 pend_q, pend_n;
  logic                 rst_done_n, flush_done_n;
  logic                 last_set;

  assign last_set = (set_q == LAST_SET);

  // Reset lands in RST_ISSUE so a power-up sweep starts without rst_start.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= RST_ISSUE;
      set_q      <= '0;
      pend_q     <= 1'b0;
      rst_done   <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      state_q    <= state_n;
      set_q      <= set_n;
      pend_q     <= pend_n;
      rst_done   <= rst_done_n;
      flush_done <= flush_done_n;
    end
  end

  always_comb begin
    state_n      = state_q;
    set_n        = set_q;
    pend_n       = pend_q;
    rst_done_n   = 1'b0;
    flush_done_n = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rst_start) begin
          state_n = RST_ISSUE;
          set_n   = '0;
          pend_n  = pend_q | flush_start;
        end else if (flush_start || pend_q) begin
          state_n = FL_ISSUE;
          set_n   = '0;
          pend_n  = 1'b0;
        end
      end
      RST_ISSUE, RST_WAIT: begin
        pend_n = pend_q | flush_start;
        if (rst_start) begin
          state_n = RST_ISSUE;
          set_n   = '0;
        end else if (state_q == RST_ISSUE) begin
          if (grant_ready) state_n = RST_WAIT;
        end else if (incr_rst_flush_stalled_set) begin
          if (last_set) begin
            state_n    = IDLE;
            set_n      = '0;
            rst_done_n = 1'b1;
          end else begin
            state_n = RST_ISSUE;
            set_n   = set_q + SET_W'(1);
          end
        end
      end
      FL_ISSUE, FL_WAIT: begin
        // Reset preempts an in-flight flush and drops any queued flush.
        if (rst_start) begin
          state_n = RST_ISSUE;
          set_n   = '0;
          pend_n  = 1'b0;
        end else begin
          pend_n = pend_q | flush_start;
          if (state_q == FL_ISSUE) begin
            if (grant_ready) state_n = FL_WAIT;
          end else if (incr_rst_flush_stalled_set) begin
            if (last_set) begin
              state_n      = IDLE;
              set_n        = '0;
              flush_done_n = 1'b1;
            end else begin
              state_n = FL_ISSUE;
              set_n   = set_q + SET_W'(1);
            end
          end
        end
      end
      default: begin
        state_n = IDLE;
        set_n   = '0;
      end
    endcase
  end

  always_comb begin
    is_rst_to_resume   = (state_q == RST_ISSUE);
    is_flush_to_resume = (state_q == FL_ISSUE);
    rst_flush_busy     = (state_q != IDLE);
  end

  if (SET_W == LLC_SET_BITS) begin : g_pkg_set
    llc_set_t set_pkg;
    assign set_pkg       = llc_set_t'(set_q);
    assign rst_flush_set = set_pkg;
  end else begin : g_raw_set
    assign rst_flush_set = set_q;
  end

`ifdef LLC_RST_FLUSH_WDOG_EN
  logic in_wait;
  assign in_wait = (state_q == RST_WAIT) || (state_q == FL_WAIT);

  llc_rst_flush_wdog #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .in_wait(in_wait),
    .err    (rst_flush_err)
  );
`else
  assign rst_flush_err = 1'b0;
`endif

endmodule

// File: tb/tb_llc_rst_flush_seq.sv
// Directed bench for llc_rst_flush_seq with NUM_SETS=4, WDOG_CYCLES=16.
module tb_llc_rst_flush_seq;

  localparam int unsigned NS = 4;
  localparam int unsigned SW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rst_start = 1'b0;
  logic          flush_start = 1'b0;
  logic          grant_ready = 1'b0;
  logic          incr = 1'b0;
  logic          is_rst_to_resume;
  logic          is_flush_to_resume;
  logic [SW-1:0] rst_flush_set;
  logic          rst_flush_busy;
  logic          rst_done;
  logic          flush_done;
  logic          rst_flush_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  llc_rst_flush_seq #(
    .NUM_SETS   (NS),
    .SET_W      (SW),
    .WDOG_CYCLES(16)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .rst_start                 (rst_start),
    .flush_start               (flush_start),
    .grant_ready               (grant_ready),
    .incr_rst_flush_stalled_set(incr),
    .is_rst_to_resume          (is_rst_to_resume),
    .is_flush_to_resume        (is_flush_to_resume),
    .rst_flush_set             (rst_flush_set),
    .rst_flush_busy            (rst_flush_busy),
    .rst_done                  (rst_done),
    .flush_done                (flush_done),
    .rst_flush_err             (rst_flush_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply reset for one edge; on return the current cycle is sweep cycle 0.
  task automatic do_reset();
    rst = 1'b0; rst_start = 1'b0; flush_start = 1'b0; grant_ready = 1'b0; incr = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    checks += 7;
    if (is_rst_to_resume !== 1'b1) begin errors++; $display("FAIL rst_req got %b exp 1", is_rst_to_resume); end
    if (is_flush_to_resume !== 1'b0) begin errors++; $display("FAIL rst_flreq got %b exp 0", is_flush_to_resume); end
    if (rst_flush_set !== 2'd0) begin errors++; $display("FAIL rst_set got %0d exp 0", rst_flush_set); end
    if (rst_flush_busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b exp 1", rst_flush_busy); end
    if (rst_done !== 1'b0) begin errors++; $display("FAIL rst_rdone got %b exp 0", rst_done); end
    if (flush_done !== 1'b0) begin errors++; $display("FAIL rst_fdone got %b exp 0", flush_done); end
    if (rst_flush_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", rst_flush_err); end
    rst = 1'b1;
  endtask

  task automatic test_powerup();
    grant_ready = 1'b1; incr = 1'b1;
    for (int c = 0; c < 8; c++) begin
      checks += 3;
      if (rst_flush_set !== SW'(c / 2)) begin errors++; $display("FAIL pu_set c=%0d got %0d exp %0d", c, rst_flush_set, c / 2); end
      if (is_rst_to_resume !== ((c % 2) == 0)) begin errors++; $display("FAIL pu_req c=%0d got %b exp %b", c, is_rst_to_resume, (c % 2) == 0); end
      if (rst_done !== 1'b0) begin errors++; $display("FAIL pu_early_done c=%0d got %b exp 0", c, rst_done); end
      tick();
    end
    checks += 3;
    if (rst_done !== 1'b1) begin errors++; $display("FAIL pu_done got %b exp 1", rst_done); end
    if (rst_flush_busy !== 1'b0) begin errors++; $display("FAIL pu_busy got %b exp 0", rst_flush_busy); end
    if (is_rst_to_resume !== 1'b0) begin errors++; $display("FAIL pu_idle_req got %b exp 0", is_rst_to_resume); end
    grant_ready = 1'b0; incr = 1'b0;
    tick();
    checks += 2;
    if (rst_done !== 1'b0) begin errors++; $display("FAIL pu_done_pulse got %b exp 0", rst_done); end
    if (rst_flush_busy !== 1'b0) begin errors++; $display("FAIL pu_idle_busy got %b exp 0", rst_flush_busy); end
  endtask

  task automatic test_grant_stall();
    int done_c;
    int fd_c;
    do_reset();
    grant_ready = 1'b1; incr = 1'b1;
    repeat (4) tick();
    grant_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (is_rst_to_resume !== 1'b1 || rst_flush_set !== 2'd2) begin
        errors++; $display("FAIL stall_hold i=%0d got req=%b set=%0d exp req=1 set=2", i, is_rst_to_resume, rst_flush_set);
      end
      tick();
    end
    grant_ready = 1'b1;
    done_c = -1;
    for (int c = 9; c < 40; c++) begin
      if (rst_done === 1'b1) begin done_c = c; break; end
      tick();
    end
    checks++;
    if (done_c != 13) begin errors++; $display("FAIL stall_done_cycle got %0d exp 13", done_c); end
    // flush_start in the same cycle as rst_done
    flush_start = 1'b1;
    tick();
    flush_start = 1'b0;
    checks++;
    if (is_flush_to_resume !== 1'b1 || rst_flush_set !== 2'd0) begin
      errors++; $display("FAIL done_flush_start got req=%b set=%0d exp req=1 set=0", is_flush_to_resume, rst_flush_set);
    end
    fd_c = -1;
    for (int c = 0; c < 30; c++) begin
      if (flush_done === 1'b1) begin fd_c = c; break; end
      tick();
    end
    checks++;
    if (fd_c != 8) begin errors++; $display("FAIL done_flush_len got %0d exp 8", fd_c); end
    grant_ready = 1'b0; incr = 1'b0;
    tick();
  endtask

  task automatic test_pending_flush();
    do_reset();
    grant_ready = 1'b1; incr = 1'b1;
    repeat (2) tick();
    flush_start = 1'b1;
    tick();
    flush_start = 1'b0;
    for (int c = 3; c < 8; c++) begin
      checks++;
      if (flush_done !== 1'b0 || rst_done !== 1'b0) begin errors++; $display("FAIL pend_early c=%0d got fd=%b rd=%b exp 0 0", c, flush_done, rst_done); end
      tick();
    end
    checks += 2;
    if (rst_done !== 1'b1) begin errors++; $display("FAIL pend_rdone got %b exp 1", rst_done); end
    if (is_flush_to_resume !== 1'b0) begin errors++; $display("FAIL pend_idle_req got %b exp 0", is_flush_to_resume); end
    tick();
    checks += 3;
    if (is_flush_to_resume !== 1'b1) begin errors++; $display("FAIL pend_fl_req got %b exp 1", is_flush_to_resume); end
    if (rst_flush_set !== 2'd0) begin errors++; $display("FAIL pend_fl_set got %0d exp 0", rst_flush_set); end
    if (is_rst_to_resume !== 1'b0) begin errors++; $display("FAIL pend_rst_req got %b exp 0", is_rst_to_resume); end
    for (int c = 9; c < 17; c++) begin
      checks++;
      if (flush_done !== 1'b0) begin errors++; $display("FAIL pend_fdone_early c=%0d got %b exp 0", c, flush_done); end
      tick();
    end
    checks += 2;
    if (flush_done !== 1'b1) begin errors++; $display("FAIL pend_fdone got %b exp 1", flush_done); end
    if (rst_flush_busy !== 1'b0) begin errors++; $display("FAIL pend_busy got %b exp 0", rst_flush_busy); end
    tick();
    checks++;
    if (rst_flush_busy !== 1'b0 || is_flush_to_resume !== 1'b0) begin
      errors++; $display("FAIL pend_cleared got busy=%b req=%b exp 0 0", rst_flush_busy, is_flush_to_resume);
    end
    grant_ready = 1'b0; incr = 1'b0;
  endtask

  task automatic test_preempt();
    int  done_c;
    logic seen_fd;
    flush_start = 1'b1;
    tick();
    flush_start = 1'b0;
    checks++;
    if (is_flush_to_resume !== 1'b1 || rst_flush_set !== 2'd0) begin
      errors++; $display("FAIL pre_start got req=%b set=%0d exp 1 0", is_flush_to_resume, rst_flush_set);
    end
    grant_ready = 1'b1; incr = 1'b1;
    repeat (4) tick();
    checks++;
    if (is_flush_to_resume !== 1'b1 || rst_flush_set !== 2'd2) begin
      errors++; $display("FAIL pre_at_set2 got req=%b set=%0d exp 1 2", is_flush_to_resume, rst_flush_set);
    end
    rst_start = 1'b1;
    tick();
    rst_start = 1'b0;
    checks += 3;
    if (is_rst_to_resume !== 1'b1) begin errors++; $display("FAIL pre_rst_req got %b exp 1", is_rst_to_resume); end
    if (rst_flush_set !== 2'd0) begin errors++; $display("FAIL pre_rst_set got %0d exp 0", rst_flush_set); end
    if (is_flush_to_resume !== 1'b0) begin errors++; $display("FAIL pre_fl_req got %b exp 0", is_flush_to_resume); end
    seen_fd = 1'b0;
    done_c = -1;
    for (int c = 5; c < 31; c++) begin
      if (flush_done === 1'b1) seen_fd = 1'b1;
      if (rst_done === 1'b1 && done_c < 0) done_c = c;
      tick();
    end
    checks += 3;
    if (seen_fd !== 1'b0) begin errors++; $display("FAIL pre_no_fdone got %b exp 0", seen_fd); end
    if (done_c != 13) begin errors++; $display("FAIL pre_rdone_cycle got %0d exp 13", done_c); end
    if (rst_flush_busy !== 1'b0) begin errors++; $display("FAIL pre_idle got busy=%b exp 0", rst_flush_busy); end
    grant_ready = 1'b0; incr = 1'b0;
  endtask

  task automatic test_mid_reset();
    int done_c;
    flush_start = 1'b1;
    tick();
    flush_start = 1'b0;
    grant_ready = 1'b1; incr = 1'b1;
    repeat (3) tick();
    flush_start = 1'b1;
    tick();
    flush_start = 1'b0;
    repeat (3) tick();
    checks++;
    if (rst_flush_set !== 2'd3 || is_flush_to_resume !== 1'b0 || rst_flush_busy !== 1'b1) begin
      errors++; $display("FAIL mid_flwait got set=%0d req=%b busy=%b exp 3 0 1", rst_flush_set, is_flush_to_resume, rst_flush_busy);
    end
    incr = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks += 3;
    if (is_rst_to_resume !== 1'b1) begin errors++; $display("FAIL mid_rst_req got %b exp 1", is_rst_to_resume); end
    if (rst_flush_set !== 2'd0) begin errors++; $display("FAIL mid_rst_set got %0d exp 0", rst_flush_set); end
    if (flush_done !== 1'b0) begin errors++; $display("FAIL mid_fdone got %b exp 0", flush_done); end
    incr = 1'b1;
    done_c = -1;
    for (int c = 0; c < 30; c++) begin
      if (rst_done === 1'b1) begin done_c = c; break; end
      tick();
    end
    checks++;
    if (done_c != 8) begin errors++; $display("FAIL mid_rdone_cycle got %0d exp 8", done_c); end
    tick();
    checks++;
    if (rst_flush_busy !== 1'b0) begin errors++; $display("FAIL mid_pend_cleared got busy=%b exp 0", rst_flush_busy); end
    grant_ready = 1'b0; incr = 1'b0;
  endtask

  task automatic test_back_to_back();
    int done_c;
    rst_start = 1'b1; flush_start = 1'b1;
    tick();
    rst_start = 1'b0; flush_start = 1'b0;
    checks++;
    if (is_rst_to_resume !== 1'b1 || is_flush_to_resume !== 1'b0) begin
      errors++; $display("FAIL b2b_rst_first got rreq=%b freq=%b exp 1 0", is_rst_to_resume, is_flush_to_resume);
    end
    grant_ready = 1'b1; incr = 1'b1;
    done_c = -1;
    for (int c = 0; c < 30; c++) begin
      if (rst_done === 1'b1) begin done_c = c; break; end
      tick();
    end
    checks++;
    if (done_c != 8) begin errors++; $display("FAIL b2b_rdone got %0d exp 8", done_c); end
    tick();
    checks++;
    if (is_flush_to_resume !== 1'b1 || rst_flush_set !== 2'd0) begin
      errors++; $display("FAIL b2b_flush got req=%b set=%0d exp 1 0", is_flush_to_resume, rst_flush_set);
    end
    done_c = -1;
    for (int c = 0; c < 30; c++) begin
      if (flush_done === 1'b1) begin done_c = c; break; end
      tick();
    end
    checks++;
    if (done_c != 8) begin errors++; $display("FAIL b2b_fdone got %0d exp 8", done_c); end
    grant_ready = 1'b0; incr = 1'b0;
    tick();
  endtask

  task automatic test_wdog();
    int done_c;
    do_reset();
    grant_ready = 1'b1; incr = 1'b0;
    tick();
`ifdef LLC_RST_FLUSH_WDOG_EN
    for (int c = 1; c <= 16; c++) begin
      checks++;
      if (rst_flush_err !== 1'b0) begin errors++; $display("FAIL wd_early c=%0d got %b exp 0", c, rst_flush_err); end
      tick();
    end
    checks++;
    if (rst_flush_err !== 1'b1) begin errors++; $display("FAIL wd_set got %b exp 1", rst_flush_err); end
`else
    repeat (40) tick();
    checks++;
    if (rst_flush_err !== 1'b0) begin errors++; $display("FAIL wd_off got %b exp 0", rst_flush_err); end
`endif
    checks++;
    if (rst_flush_busy !== 1'b1 || is_rst_to_resume !== 1'b0 || rst_flush_set !== 2'd0) begin
      errors++; $display("FAIL wd_waiting got busy=%b req=%b set=%0d exp 1 0 0", rst_flush_busy, is_rst_to_resume, rst_flush_set);
    end
    incr = 1'b1;
    done_c = -1;
    for (int c = 0; c < 30; c++) begin
      if (rst_done === 1'b1) begin done_c = c; break; end
      tick();
    end
    checks += 2;
    if (done_c != 7) begin errors++; $display("FAIL wd_resume_done got %0d exp 7", done_c); end
`ifdef LLC_RST_FLUSH_WDOG_EN
    if (rst_flush_err !== 1'b1) begin errors++; $display("FAIL wd_sticky got %b exp 1", rst_flush_err); end
`else
    if (rst_flush_err !== 1'b0) begin errors++; $display("FAIL wd_off_end got %b exp 0", rst_flush_err); end
`endif
    grant_ready = 1'b0; incr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_grant_stall();
    test_pending_flush();
    test_preempt();
    test_mid_reset();
    test_back_to_back();
    test_wdog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
